// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller and the freeze logic:
// mem_state status codes and the controller FSM encoding.
package mem_pkg;

  localparam int unsigned MEM_STATE_W = 3;

  // Status codes published on mem_state; the freeze logic decodes these too.
  localparam logic [MEM_STATE_W-1:0] MEM_FREE  = 3'b000;
  localparam logic [MEM_STATE_W-1:0] MEM_STALL = 3'b111;
  localparam logic [MEM_STATE_W-1:0] MEM_DONE  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  // Status code shown to the freeze logic while the FSM sits in state s.
  function automatic logic [MEM_STATE_W-1:0] state_code(input fsm_state_e s);
    case (s)
      ST_IDLE: return MEM_FREE;
      ST_DONE: return MEM_DONE;
      default: return MEM_STALL;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Watchdog counter for the WAIT state. Cleared on entry to WAIT, counts each
// enabled cycle; expired_c is high in the enabled cycle that reaches TO_CYC.
module mem_timeout_cnt #(
  parameter int unsigned TO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q;

  // Count WAIT cycles; hold at the limit so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CW'(TO_CYC))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The current WAIT cycle is the TO_CYC-th one (count is zero in the first).
  assign expired_c = en && (cnt_q == CW'(TO_CYC - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: runs the single-word request/ready handshake with
// external memory and publishes the mem_state code consumed by the freeze logic.
// Optional watchdog on WAIT enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic [MEM_STATE_W-1:0] mem_state,
  output logic                   mem_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   mem_ready
);

  fsm_state_e              state_q;
  fsm_state_e              state_d;
  logic [MEM_STATE_W-1:0]  mem_state_d;
  logic                    mem_req_d;
  logic                    mem_we_d;
  logic [AW-1:0]           mem_addr_d;
  logic [DW-1:0]           mem_wdata_d;
  logic [DW-1:0]           cpu_rdata_d;
  logic                    mem_err_d;
  logic                    to_expired_c;

`ifdef MEM_TIMEOUT_EN
  logic cnt_clr_c;
  logic cnt_en_c;

  // Counter restarts while in REQ so it reads zero in the first WAIT cycle.
  assign cnt_clr_c = (state_q == ST_REQ);
  assign cnt_en_c  = (state_q == ST_WAIT);

  mem_timeout_cnt #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr_c),
    .en        (cnt_en_c),
    .expired_c (to_expired_c)
  );
`else
  // Watchdog absent: WAIT lasts until memory answers.
  localparam int unsigned unused_to_cyc = TO_CYC;
  assign to_expired_c = 1'b0;
`endif

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_rdata_d = cpu_rdata;
    mem_err_d   = mem_err;

    case (state_q)
      ST_IDLE: begin
        if (cpu_rd || cpu_wr) begin
          state_d     = ST_REQ;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          // A simultaneous read and write proceeds as a write and is flagged.
          mem_we_d    = cpu_wr;
          if (cpu_rd && cpu_wr) begin
            mem_err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready on the same edge as the watchdog limit is a clean completion.
        if (mem_ready) begin
          if (!mem_we) begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (to_expired_c) begin
          mem_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d   = (state_d == ST_REQ);
    mem_state_d = state_code(state_d);
  end

  // State and output registers; reset discards any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mem_state <= MEM_FREE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_state <= mem_state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_rdata <= cpu_rdata_d;
      mem_err   <= mem_err_d;
    end
  end

endmodule
